mrr_decode_stream_arbiter: RTL and testbench

Packet-atomic round-robin arbiter that merges the per-pathway decoded AXI-Stream outputs of the MRR gateway decode pathways into one 32-bit stream toward the host. It sits downstream of the per-pathway loopback/decoder instances. A granted pathway keeps the output until it delivers tlast. A per-grant stall watchdog recovers the shared output from a pathway that stops mid-packet.

---
 rtl/mrr_decode_stream_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mrr_decode_stream_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mrr_decode_stream_arbiter.sv
// mrr_decode_stream_arbiter
//   Packet-atomic round-robin merge of the per-pathway decoded AXI-Stream
//   outputs into one 32-bit stream toward the host. A granted pathway owns
//   the output until it delivers tlast. If it stalls mid-packet for
//   TIMEOUT_CYCLES consecutive cycles, the packet is closed with a pad word
//   (32'hDEAD_0000 | pathway) and the pathway loses the grant.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_tdata        : per-pathway data, pathway k at [32k+31:32k]
//   i_tvalid       : per-pathway valid
//   i_tlast        : per-pathway end of packet
//   i_tready       : per-pathway ready, only ever toward the granted pathway
//   o_tdata/o_tid/o_tlast/o_tvalid : registered merged stream
//   o_tready       : downstream ready
//   abort_count    : forced aborts since reset, saturating at 16'hFFFF
//   busy           : arbiter mid-packet or output register occupied
module mrr_decode_stream_arbiter #(
    parameter int unsigned NUM_PATHWAYS   = 4,
    parameter int unsigned ID_WIDTH       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TIMEOUT_WIDTH  = 11
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [32*NUM_PATHWAYS-1:0] i_tdata,
    input  logic [NUM_PATHWAYS-1:0]   i_tvalid,
    input  logic [NUM_PATHWAYS-1:0]   i_tlast,
    output logic [NUM_PATHWAYS-1:0]   i_tready,
    output logic [31:0]               o_tdata,
    output logic [ID_WIDTH-1:0]       o_tid,
    output logic                      o_tlast,
    output logic                      o_tvalid,
    input  logic                      o_tready,
    output logic [15:0]               abort_count,
    output logic                      busy
);

    localparam int unsigned IDX_W = (NUM_PATHWAYS > 1) ? $clog2(NUM_PATHWAYS) : 1;
    localparam logic [TIMEOUT_WIDTH-1:0] STALL_MAX = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] PAD_WORD = 32'hDEAD_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t                   state, state_nx;
    logic [ID_WIDTH-1:0]      grant, grant_nx;
    logic [ID_WIDTH-1:0]      rr_ptr, rr_ptr_nx;
    logic [TIMEOUT_WIDTH-1:0] stall_cnt, stall_cnt_nx;

    logic [31:0]              lane_data [NUM_PATHWAYS];
    logic [IDX_W-1:0]         gsel;
    logic                     g_valid, g_last;
    logic [31:0]              g_data;
    logic [ID_WIDTH-1:0]      next_of_grant;

    logic                     out_free;
    logic                     load, load_last, abort_inc;
    logic [31:0]              load_data;

    logic                     hit;
    logic [IDX_W-1:0]         cand;
    logic [ID_WIDTH-1:0]      hit_idx;

    for (genvar k = 0; k < NUM_PATHWAYS; k++) begin : g_lane
        assign lane_data[k] = i_tdata[32*k +: 32];
    end

    assign gsel     = grant[IDX_W-1:0];
    assign g_valid  = i_tvalid[gsel];
    assign g_last   = i_tlast[gsel];
    assign g_data   = lane_data[gsel];
    assign out_free = !o_tvalid || o_tready;
    assign busy     = (state != IDLE) || o_tvalid;
    assign next_of_grant = (32'(grant) == NUM_PATHWAYS - 1) ? '0 : grant + ID_WIDTH'(1);

    // Rotating priority search: first valid pathway at or after rr_ptr.
    always_comb begin
        hit     = 1'b0;
        cand    = '0;
        hit_idx = '0;
        for (int unsigned off = 0; off < NUM_PATHWAYS; off++) begin
            cand = IDX_W'((32'(rr_ptr) + off) % NUM_PATHWAYS);
            if (!hit && i_tvalid[cand]) begin
                hit     = 1'b1;
                hit_idx = ID_WIDTH'(cand);
            end
        end
    end

    always_comb begin
        state_nx     = state;
        grant_nx     = grant;
        rr_ptr_nx    = rr_ptr;
        stall_cnt_nx = stall_cnt;
        i_tready     = '0;
        load         = 1'b0;
        load_data    = g_data;
        load_last    = g_last;
        abort_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    grant_nx     = hit_idx;
                    state_nx     = PASS;
                    stall_cnt_nx = '0;
                end
            end
            PASS: begin
                i_tready[gsel] = out_free;
                if (g_valid && out_free) begin
                    load         = 1'b1;
                    stall_cnt_nx = '0;
                    if (g_last) begin
                        state_nx  = IDLE;
                        rr_ptr_nx = next_of_grant;
                    end
                end else if (!g_valid) begin
                    // Only source-side silence counts; downstream backpressure does not.
                    stall_cnt_nx = stall_cnt + TIMEOUT_WIDTH'(1);
                    if (stall_cnt == STALL_MAX) begin
                        state_nx = ABORT;
                    end
                end
            end
            ABORT: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_data = PAD_WORD | 32'(grant);
                    load_last = 1'b1;
                    abort_inc = 1'b1;
                    rr_ptr_nx = next_of_grant;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            stall_cnt   <= '0;
            o_tdata     <= '0;
            o_tid       <= '0;
            o_tlast     <= 1'b0;
            o_tvalid    <= 1'b0;
            abort_count <= '0;
        end else begin
            state     <= state_nx;
            grant     <= grant_nx;
            rr_ptr    <= rr_ptr_nx;
            stall_cnt <= stall_cnt_nx;
            if (load) begin
                o_tdata  <= load_data;
                o_tid    <= grant;
                o_tlast  <= load_last;
                o_tvalid <= 1'b1;
            end else if (o_tready) begin
                o_tvalid <= 1'b0;
            end
            if (abort_inc && abort_count != 16'hFFFF) begin
                abort_count <= abort_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mrr_decode_stream_arbiter.sv
module tb_mrr_decode_stream_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [127:0] i_tdata = '0;
    logic [3:0]   i_tvalid = '0;
    logic [3:0]   i_tlast = '0;
    logic [3:0]   i_tready;
    logic [31:0]  o_tdata;
    logic [1:0]   o_tid;
    logic         o_tlast;
    logic         o_tvalid;
    logic         o_tready = 1'b0;
    logic [15:0]  abort_count;
    logic         busy;

    mrr_decode_stream_arbiter #(
        .NUM_PATHWAYS  (4),
        .ID_WIDTH      (2),
        .TIMEOUT_CYCLES(8),
        .TIMEOUT_WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_tdata    (i_tdata),
        .i_tvalid   (i_tvalid),
        .i_tlast    (i_tlast),
        .i_tready   (i_tready),
        .o_tdata    (o_tdata),
        .o_tid      (o_tid),
        .o_tlast    (o_tlast),
        .o_tvalid   (o_tvalid),
        .o_tready   (o_tready),
        .abort_count(abort_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  id;
        logic        last;
        int          c;
    } beat_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          vstart [4];
    logic [32:0] src_q [4][$];
    logic [3:0]  hs = '0;
    beat_t       out_q [$];

    always @(posedge clk) cyc++;

    // Upstream sources: each pathway presents the head of its queue.
    always @(negedge clk) hs = i_tvalid & i_tready;

    always @(posedge clk) begin
        logic [32:0] w;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
            if (src_q[k].size() > 0) begin
                w = src_q[k][0];
                if (!i_tvalid[k]) vstart[k] = cyc;
                i_tvalid[k]           = 1'b1;
                i_tdata[32*k +: 32]   = w[31:0];
                i_tlast[k]            = w[32];
            end else begin
                i_tvalid[k] = 1'b0;
                i_tlast[k]  = 1'b0;
            end
        end
        hs = '0;
    end

    // Downstream monitor: record every transferred word.
    always @(negedge clk) begin
        if (rst_n && o_tvalid && o_tready)
            out_q.push_back('{d: o_tdata, id: o_tid, last: o_tlast, c: cyc});
    end

    task automatic settle();
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        out_q.delete();
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_tdata, o_tid, o_tlast, o_tvalid, i_tready, abort_count, busy} !== '0)
            $display("FAIL reset_state: got %h expected 0",
                     {o_tdata, o_tid, o_tlast, o_tvalid, i_tready, abort_count, busy});
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        o_tready = 1'b1;
    endtask

    task automatic test_single();
        logic [31:0] exp_d [3];
        exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33;
        src_q[2].push_back({1'b0, 32'h11});
        src_q[2].push_back({1'b0, 32'h22});
        src_q[2].push_back({1'b1, 32'h33});
        for (int i = 0; i < 30 && out_q.size() < 3; i++) @(negedge clk);
        n_cmp++;
        if (out_q.size() != 3) begin
            $display("FAIL single_count: got %0d words expected 3", out_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if ({out_q[i].d, out_q[i].id, out_q[i].last} !== {exp_d[i], 2'd2, (i == 2)}) begin
                    n_err++;
                    $display("FAIL single_word%0d: got %h/%0d/%b expected %h/2/%b",
                             i, out_q[i].d, out_q[i].id, out_q[i].last, exp_d[i], (i == 2));
                end
            end
            n_cmp++;
            if (out_q[0].c - vstart[2] !== 2) begin
                n_err++;
                $display("FAIL single_latency: got %0d expected 2", out_q[0].c - vstart[2]);
            end
            n_cmp++;
            if (out_q[2].c - out_q[0].c !== 2) begin
                n_err++;
                $display("FAIL single_consecutive: got span %0d expected 2", out_q[2].c - out_q[0].c);
            end
        end
        if (out_q.size() != 3) n_err++;
        settle();
    endtask

    task automatic test_round_robin();
        logic [31:0] ed;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 2; j++)
                src_q[k].push_back({(j == 1), 32'hC000_0000 | 32'(k << 4) | 32'(j)});
        for (int i = 0; i < 80 && out_q.size() < 8; i++) @(negedge clk);
        n_cmp++;
        if (out_q.size() != 8) begin
            n_err++;
            $display("FAIL rr_count: got %0d words expected 8", out_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                ed = 32'hC000_0000 | 32'((i / 2) << 4) | 32'(i % 2);
                n_cmp++;
                if ({out_q[i].d, out_q[i].id, out_q[i].last} !== {ed, 2'(i / 2), (i % 2 == 1)}) begin
                    n_err++;
                    $display("FAIL rr_word%0d: got %h/%0d/%b expected %h/%0d/%b",
                             i, out_q[i].d, out_q[i].id, out_q[i].last, ed, i / 2, (i % 2 == 1));
                end
            end
            n_cmp++;
            if (out_q[7].c - out_q[0].c !== 10) begin
                n_err++;
                $display("FAIL rr_span: got %0d cycles expected 10", out_q[7].c - out_q[0].c);
            end
        end
        settle();
    endtask

    task automatic test_backpressure();
        logic        prev_hold = 1'b0;
        logic [31:0] prev_d = '0;
        for (int j = 0; j < 4; j++) src_q[0].push_back({(j == 3), 32'hB0 + 32'(j)});
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1 o_tready = (i == 0) || (i == 3) || (i >= 14);
            @(negedge clk);
            if (prev_hold) begin
                n_cmp++;
                if (!o_tvalid || o_tdata !== prev_d) begin
                    n_err++;
                    $display("FAIL bp_hold: got %b/%h expected 1/%h", o_tvalid, o_tdata, prev_d);
                end
            end
            prev_hold = o_tvalid && !o_tready;
            prev_d    = o_tdata;
        end
        n_cmp++;
        if (out_q.size() != 4) begin
            n_err++;
            $display("FAIL bp_count: got %0d words expected 4", out_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if ({out_q[i].d, out_q[i].id, out_q[i].last} !== {32'hB0 + 32'(i), 2'd0, (i == 3)}) begin
                    n_err++;
                    $display("FAIL bp_word%0d: got %h/%0d/%b expected %h/0/%b",
                             i, out_q[i].d, out_q[i].id, out_q[i].last, 32'hB0 + 32'(i), (i == 3));
                end
            end
        end
        n_cmp++;
        if (abort_count !== 16'd0) begin
            n_err++;
            $display("FAIL bp_no_abort: got %0d expected 0", abort_count);
        end
        settle();
    endtask

    task automatic test_timeout();
        src_q[1].push_back({1'b0, 32'h55});
        src_q[2].push_back({1'b1, 32'h2222});
        for (int i = 0; i < 60 && out_q.size() < 3; i++) @(negedge clk);
        n_cmp++;
        if (out_q.size() != 3) begin
            n_err++;
            $display("FAIL to_count: got %0d words expected 3", out_q.size());
        end else begin
            n_cmp++;
            if ({out_q[0].d, out_q[0].id, out_q[0].last} !== {32'h55, 2'd1, 1'b0}) begin
                n_err++;
                $display("FAIL to_first: got %h/%0d/%b expected 00000055/1/0",
                         out_q[0].d, out_q[0].id, out_q[0].last);
            end
            n_cmp++;
            if ({out_q[1].d, out_q[1].id, out_q[1].last} !== {32'hDEAD_0001, 2'd1, 1'b1}) begin
                n_err++;
                $display("FAIL to_pad: got %h/%0d/%b expected dead0001/1/1",
                         out_q[1].d, out_q[1].id, out_q[1].last);
            end
            n_cmp++;
            if (out_q[1].c - out_q[0].c !== 9) begin
                n_err++;
                $display("FAIL to_delay: got %0d cycles expected 9", out_q[1].c - out_q[0].c);
            end
            n_cmp++;
            if ({out_q[2].d, out_q[2].id, out_q[2].last} !== {32'h2222, 2'd2, 1'b1}) begin
                n_err++;
                $display("FAIL to_next: got %h/%0d/%b expected 00002222/2/1",
                         out_q[2].d, out_q[2].id, out_q[2].last);
            end
        end
        n_cmp++;
        if (abort_count !== 16'd1) begin
            n_err++;
            $display("FAIL to_abort_count: got %0d expected 1", abort_count);
        end
        settle();
    endtask

    task automatic test_reset_mid();
        for (int j = 0; j < 5; j++) src_q[0].push_back({(j == 4), 32'hE0 + 32'(j)});
        for (int i = 0; i < 30 && out_q.size() < 2; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        for (int k = 0; k < 4; k++) src_q[k].delete();
        hs = '0;
        #1;
        n_cmp++;
        if ({o_tdata, o_tid, o_tlast, o_tvalid, i_tready, abort_count, busy} !== '0) begin
            n_err++;
            $display("FAIL mid_reset_state: got %h expected 0",
                     {o_tdata, o_tid, o_tlast, o_tvalid, i_tready, abort_count, busy});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_q.delete();
        src_q[0].push_back({1'b0, 32'h77});
        src_q[0].push_back({1'b1, 32'h88});
        for (int i = 0; i < 30 && out_q.size() < 2; i++) @(negedge clk);
        n_cmp++;
        if (out_q.size() != 2) begin
            n_err++;
            $display("FAIL mid_after_count: got %0d words expected 2", out_q.size());
        end else begin
            n_cmp++;
            if ({out_q[0].d, out_q[0].id, out_q[0].last, out_q[1].d, out_q[1].id, out_q[1].last}
                !== {32'h77, 2'd0, 1'b0, 32'h88, 2'd0, 1'b1}) begin
                n_err++;
                $display("FAIL mid_after_data: got %h,%h expected 00000077,00000088",
                         out_q[0].d, out_q[1].d);
            end
        end
        settle();
    endtask

    task automatic run_abort(output bit ok);
        out_q.delete();
        src_q[3].push_back({1'b0, 32'h3333});
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_q.size() >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    endtask

    task automatic test_abort_saturation();
        bit ok;
        force dut.abort_count = 16'hFFFE;
        run_abort(ok);
        release dut.abort_count;
        n_cmp++;
        if (ok !== 1'b1) begin
            n_err++;
            $display("FAIL sat_abort1: got %b expected 1", ok);
        end
        run_abort(ok);
        n_cmp++;
        if (ok !== 1'b1 || out_q[1].d !== 32'hDEAD_0003 || out_q[1].id !== 2'd3) begin
            n_err++;
            $display("FAIL sat_pad: got ok=%b word %h expected 1 word dead0003", ok,
                     (out_q.size() >= 2) ? out_q[1].d : 32'h0);
        end
        n_cmp++;
        if (abort_count !== 16'hFFFF) begin
            n_err++;
            $display("FAIL sat_value2: got %h expected ffff", abort_count);
        end
        run_abort(ok);
        n_cmp++;
        if (abort_count !== 16'hFFFF) begin
            n_err++;
            $display("FAIL sat_value3: got %h expected ffff", abort_count);
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_abort_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
